// File: rtl/fetch_queue_pkg.sv
// Shared widths, PC increment and queue entry type for the instruction fetch front end.
package fetch_queue_pkg;

   localparam int          WORD_BITS  = 32;
   localparam int          DWORD_BITS = 64;
   localparam logic [63:0] PC_STEP    = 64'd4;

   typedef struct packed {
      logic [DWORD_BITS-1:0] pc;
      logic [WORD_BITS-1:0]  instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO with registered storage; head is the oldest entry, count is 0..DEPTH.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != FULL) || do_pop);
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: sequential imem requests, in-order {pc, instr} queue to decode, redirect flush.
// Optional combinational empty-queue bypass to decode when FETCH_BYPASS_EN is defined.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [63:0] req_addr,
   input  logic        resp_valid,
   input  logic [31:0] resp_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_pc,
   output logic [31:0] out_instr
);

   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);

   logic [63:0]   fetch_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] inflight;
   logic [CW-1:0] drop;
   logic [CW-1:0] live;
   logic [63:0]   pend_pc;
   fetch_entry_t  head_q;
   fetch_entry_t  push_entry;
   logic          req_fire;
   logic          q_push;
   logic          q_pop;
   logic          bypass;
   logic          drop_resp;

   assign live      = inflight - drop;
   assign drop_resp = (drop != '0);

   // Queue space is reserved at request time; the inflight bound also keeps the pending-pc FIFO from overflowing
   // while stale responses are still outstanding after a redirect.
   assign req_valid = !reset && !redirect
                      && (({1'b0, count} + {1'b0, live}) < DEPTH_X)
                      && (inflight < DEPTH_C);
   assign req_addr  = fetch_pc;
   assign req_fire  = req_valid && req_ready;

`ifdef FETCH_BYPASS_EN
   assign bypass = !reset && !redirect && resp_valid && !drop_resp && out_ready && (count == '0);
`else
   assign bypass = 1'b0;
`endif

   assign q_push     = resp_valid && !drop_resp && !redirect && !bypass;
   assign q_pop      = (count != '0) && out_ready && !redirect;
   assign push_entry = '{pc: pend_pc, instr: resp_instr};
   assign out_valid  = (count != '0) || bypass;

   always_comb begin
      out_pc    = '0;
      out_instr = '0;
      if (bypass) begin
         out_pc    = pend_pc;
         out_instr = resp_instr;
      end else if (count != '0) begin
         out_pc    = head_q.pc;
         out_instr = head_q.instr;
      end
   end

   // A response arriving in the redirect cycle has already left inflight, so it is excluded from drop.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         drop     <= '0;
      end else if (redirect) begin
         fetch_pc <= redirect_pc;
         drop     <= inflight - CW'(resp_valid);
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
         if (resp_valid && drop_resp) drop <= drop - 1'b1;
      end
   end

   sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_pend_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (req_fire),
      .pop   (resp_valid),
      .clear (1'b0),
      .din   (fetch_pc),
      .head  (pend_pc),
      .count (inflight)
   );

   sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (q_push),
      .pop   (q_pop),
      .clear (redirect),
      .din   (push_entry),
      .head  (head_q),
      .count (count)
   );

   a_resp_has_req: assert property (@(posedge clk) disable iff (reset) !(resp_valid && (inflight == '0)));
   a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(q_push && (count == DEPTH_C)));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a latency-programmable in-order memory model.
`timescale 1ns/1ps
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        req_valid;
   logic        req_ready = 1'b1;
   logic [63:0] req_addr;
   logic        resp_valid = 1'b0;
   logic [31:0] resp_instr = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_pc;
   logic [31:0] out_instr;

   int total = 0;
   int bad   = 0;

`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   fetch_queue #(.DEPTH(4), .RESET_PC(64'h1000)) dut (
      .clk         (clk),
      .reset       (reset),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .resp_valid  (resp_valid),
      .resp_instr  (resp_instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_instr   (out_instr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mem_q[$];
   int          cyc = 0;
   int          lat = 1;
   logic [63:0] acc_q[$];
   logic [63:0] got_pc[$];
   logic [31:0] got_instr[$];
   logic        s_ov;
   logic [31:0] s_instr;

   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return (a[31:0] - 32'h1000) ^ 32'h0000_0013;
   endfunction

   // One clock cycle: drive memory response, sample DUT, advance model at the edge.
   task automatic step();
      logic        acc;
      logic [63:0] addr;
      mreq_t       m;
      resp_valid = 1'b0;
      resp_instr = '0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         resp_valid = 1'b1;
         resp_instr = instr_of(mem_q[0].addr);
      end
      #1;
      acc     = req_valid && req_ready;
      addr    = req_addr;
      s_ov    = out_valid;
      s_instr = out_instr;
      if (acc) acc_q.push_back(addr);
      if (out_valid && out_ready && !redirect && !reset) begin
         got_pc.push_back(out_pc);
         got_instr.push_back(out_instr);
      end
      @(posedge clk);
      if (reset) begin
         mem_q.delete();
      end else begin
         if (resp_valid) void'(mem_q.pop_front());
         if (acc) begin
            m.addr = addr;
            m.due  = cyc + lat;
            mem_q.push_back(m);
         end
      end
      cyc++;
      @(negedge clk);
      resp_valid = 1'b0;
   endtask

   task automatic clear_logs();
      acc_q.delete();
      got_pc.delete();
      got_instr.delete();
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      redirect = 1'b0;
      step();
      step();
      reset = 1'b0;
      clear_logs();
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      out_ready = 1'b1;
      req_ready = 1'b1;
      step();
      step();
      #1;
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%0b want=0", req_valid); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
      total++; if (out_pc !== 64'h0) begin bad++; $display("FAIL reset_out_pc got=%h want=0", out_pc); end
      total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr got=%h want=0", out_instr); end
      reset = 1'b0;
      #1;
      total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL first_req_valid got=%0b want=1", req_valid); end
      total++; if (req_addr !== 64'h1000) begin bad++; $display("FAIL first_req_addr got=%h want=1000", req_addr); end
      clear_logs();
   endtask

   task automatic test_stream();
      int first;
      lat       = 1;
      out_ready = 1'b1;
      do_reset();
      first = -1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (s_ov && first < 0) first = i;
      end
      total++; if (first != (BYP ? 1 : 2)) begin bad++; $display("FAIL stream_first_valid got=%0d want=%0d", first, BYP ? 1 : 2); end
      for (int i = 0; i < 4; i++) begin
         total++; if (acc_q[i] !== 64'h1000 + 64'(4*i)) begin bad++; $display("FAIL stream_req_addr[%0d] got=%h want=%h", i, acc_q[i], 64'h1000 + 64'(4*i)); end
         total++; if (got_pc[i] !== 64'h1000 + 64'(4*i)) begin bad++; $display("FAIL stream_out_pc[%0d] got=%h want=%h", i, got_pc[i], 64'h1000 + 64'(4*i)); end
         total++; if (got_instr[i] !== instr_of(64'h1000 + 64'(4*i))) begin bad++; $display("FAIL stream_out_instr[%0d] got=%h want=%h", i, got_instr[i], instr_of(64'h1000 + 64'(4*i))); end
      end
   endtask

   task automatic test_stall();
      lat       = 1;
      out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 10; i++) step();
      #1;
      total++; if (acc_q.size() != 4) begin bad++; $display("FAIL stall_accepts got=%0d want=4", acc_q.size()); end
      total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL stall_req_valid got=%0b want=0", req_valid); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid got=%0b want=1", out_valid); end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) step();
      for (int i = 0; i < 4; i++) begin
         total++; if (got_pc[i] !== 64'h1000 + 64'(4*i)) begin bad++; $display("FAIL stall_drain_pc[%0d] got=%h want=%h", i, got_pc[i], 64'h1000 + 64'(4*i)); end
      end
      total++; if (acc_q[4] !== 64'h1010) begin bad++; $display("FAIL stall_resume_addr got=%h want=1010", acc_q[4]); end
   endtask

   task automatic test_redirect();
      lat       = 3;
      out_ready = 1'b1;
      do_reset();
      step();
      step();
      total++; if (acc_q.size() != 2) begin bad++; $display("FAIL redir_inflight got=%0d want=2", acc_q.size()); end
      redirect    = 1'b1;
      redirect_pc = 64'h2000;
      step();
      redirect = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_out_valid got=%0b want=0", out_valid); end
      total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL redir_req_valid got=%0b want=1", req_valid); end
      total++; if (req_addr !== 64'h2000) begin bad++; $display("FAIL redir_req_addr got=%h want=2000", req_addr); end
      clear_logs();
      for (int i = 0; i < 14; i++) step();
      total++; if (got_pc[0] !== 64'h2000) begin bad++; $display("FAIL redir_first_pc got=%h want=2000", got_pc[0]); end
      total++; if (got_instr[0] !== instr_of(64'h2000)) begin bad++; $display("FAIL redir_first_instr got=%h want=%h", got_instr[0], instr_of(64'h2000)); end
      total++; if (got_pc[1] !== 64'h2004) begin bad++; $display("FAIL redir_second_pc got=%h want=2004", got_pc[1]); end
   endtask

   task automatic test_redirect_resp();
      lat       = 1;
      out_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 6; i++) step();
      redirect    = 1'b1;
      redirect_pc = 64'h3000_0002;
      step();
      redirect = 1'b0;
      total++; if (s_ov !== 1'b1) begin bad++; $display("FAIL rr_valid_in_redirect got=%0b want=1", s_ov); end
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_out_valid got=%0b want=0", out_valid); end
      total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL rr_req_valid got=%0b want=1", req_valid); end
      total++; if (req_addr !== 64'h3000_0002) begin bad++; $display("FAIL rr_req_addr got=%h want=30000002", req_addr); end
      clear_logs();
      for (int i = 0; i < 6; i++) step();
      total++; if (got_pc[0] !== 64'h3000_0002) begin bad++; $display("FAIL rr_first_pc got=%h want=30000002", got_pc[0]); end
      total++; if (got_instr[0] !== instr_of(64'h3000_0002)) begin bad++; $display("FAIL rr_first_instr got=%h want=%h", got_instr[0], instr_of(64'h3000_0002)); end
      total++; if (got_pc[1] !== 64'h3000_0006) begin bad++; $display("FAIL rr_second_pc got=%h want=30000006", got_pc[1]); end
   endtask

   task automatic test_reset_mid();
      lat       = 1;
      out_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) step();
      #1;
      total++; if (out_pc !== 64'h1000) begin bad++; $display("FAIL rmid_head_pc got=%h want=1000", out_pc); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%0b want=0", out_valid); end
      total++; if (out_pc !== 64'h0) begin bad++; $display("FAIL rmid_out_pc got=%h want=0", out_pc); end
      total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rmid_out_instr got=%h want=0", out_instr); end
      total++; if (req_valid !== 1'b1) begin bad++; $display("FAIL rmid_req_valid got=%0b want=1", req_valid); end
      total++; if (req_addr !== 64'h1000) begin bad++; $display("FAIL rmid_req_addr got=%h want=1000", req_addr); end
      clear_logs();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
      total++; if (got_pc[0] !== 64'h1000) begin bad++; $display("FAIL rmid_restart_pc0 got=%h want=1000", got_pc[0]); end
      total++; if (got_pc[1] !== 64'h1004) begin bad++; $display("FAIL rmid_restart_pc1 got=%h want=1004", got_pc[1]); end
   endtask

   task automatic test_bypass();
      lat       = 1;
      out_ready = 1'b1;
      do_reset();
      step();
      step();
      total++; if (s_ov !== BYP) begin bad++; $display("FAIL byp_valid_n got=%0b want=%0b", s_ov, BYP); end
      total++; if (s_instr !== (BYP ? 32'h13 : 32'h0)) begin bad++; $display("FAIL byp_instr_n got=%h want=%h", s_instr, BYP ? 32'h13 : 32'h0); end
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL byp_valid_n1 got=%0b want=1", out_valid); end
      total++; if (out_instr !== (BYP ? 32'h17 : 32'h13)) begin bad++; $display("FAIL byp_instr_n1 got=%h want=%h", out_instr, BYP ? 32'h17 : 32'h13); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_resp();
      test_reset_mid();
      test_bypass();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that sits directly upstream of the decode stage. It issues sequential fetch requests to a variable-latency instruction memory port and buffers returned instructions with their PCs in a small in-order queue. It presents them to decode through a valid/ready handshake and handles redirects from execute (taken branch/jump) by flushing the queue and discarding stale in-flight responses. It replaces the direct combinational `pc → imem → instr_dec` path, so that decode stalls and memory latency decouple.

## Interface
Parameters:
- `DEPTH`, 4 — queue entries; power of two, ≥2.
- `RESET_PC`, 64'h0 — fetch address after reset.

Ports:
- `clk` input 1 — clock.
- `reset` input 1 — synchronous, active-high reset.
- `redirect` input 1 — execute took branch/jump this cycle.
- `redirect_pc` input 64 — new fetch address, valid when `redirect`.
- `req_valid` output 1 — fetch request to imem.
- `req_ready` input 1 — imem accepts request.
- `req_addr` output 64 — request address.
- `resp_valid` input 1 — imem returns one instruction; in order; no backpressure.
- `resp_instr` input 32 — returned instruction word.
- `out_valid` output 1 — head entry valid to decode.
- `out_ready` input 1 — decode accepts (the inverse of `stall_dec`).
- `out_pc` output 64 — PC of head entry.
- `out_instr` output 32 — instruction of head entry.

## Operation
- State: `fetch_pc` (64), queue `count` (0..DEPTH), `inflight` (0..DEPTH) for accepted-but-unreturned requests, and `drop` (0..DEPTH) for responses to discard. A FIFO of {pc, instr} keeps the PC of each in-flight request in a parallel pc FIFO of the same depth.
- `live = inflight − drop`.
- `req_valid = !redirect && (count + live < DEPTH)`. This guarantees the queue never overflows.
- `req_addr = fetch_pc`.
- Request accept (`req_valid && req_ready`): `fetch_pc += 4` (64-bit wrap); `inflight++`; pc pushed to the pending-pc FIFO.
- Response (`resp_valid`):
  - `inflight--` and the pending pc is popped.
  - If `drop > 0`, the response is discarded and `drop--`.
  - Otherwise {pending pc, `resp_instr`} is pushed to the queue.
- Pop (`out_valid && out_ready`): the head is removed. `out_valid = (count != 0)`.
- `redirect` has priority over push and pop:
  - `fetch_pc <= redirect_pc`.
  - Queue cleared (`count <= 0`).
  - `drop <= inflight` after this cycle's response update (a response arriving in the redirect cycle is itself discarded).
  - No request is issued in the redirect cycle.
- Simultaneous push and pop: `count` is unchanged.
- Misaligned `redirect_pc` is passed through unchanged; alignment faults belong to execute.

## Timing
- Reset values: `fetch_pc = RESET_PC`, `count = inflight = drop = 0`, `req_valid = 0`, `out_valid = 0`, `out_pc = 0`, `out_instr = 0`.
- `reset` mid-operation discards everything, including in-flight responses: memory is assumed reset in the same cycle.
- First request: `req_valid = 1` in the first cycle after `reset` deasserts.
- Latency without bypass: a response in cycle N makes `out_valid = 1` in cycle N+1.
- Redirect in cycle N:
  - `out_valid = 0` in N+1.
  - `req_addr = redirect_pc` with `req_valid` in N+1.
- Outputs `out_*` come from registers except in bypass mode.
- The counters never exceed DEPTH. Assertions: `resp_valid` never arrives with `inflight == 0`; queue push never occurs when `count == DEPTH`.

## Configuration
- `FETCH_BYPASS_EN` defined: when `count == 0`, a non-dropped `resp_valid` and `out_ready` is high in cycle N, the response is presented combinationally on `out_*` with `out_valid = 1` in cycle N and is not enqueued. This gives zero added latency.
- Undefined: all responses are enqueued and exit at the earliest in N+1. `out_*` are register/FIFO-head driven only.

## Structure
- Shared defines package: `WORD_BITS`, `DWORD_BITS`, `PC_STEP` (4), typedef `fetch_entry_t` {`pc`[63:0], `instr`[31:0]}.
- One sub-module: `sync_fifo`, parameterised on width and depth, with `push`, `pop`, `clear`, `count` and head data. It is instantiated twice: the pending-pc FIFO and the entry queue.

## Test plan
- Reset with `RESET_PC=0x1000`, `req_ready=1`, 1-cycle memory → `req_addr` 0x1000, 0x1004, 0x1008…; `out_pc`/`out_instr` pairs match in order; `out_valid` first high 2 cycles after the first accept.
- `out_ready=0` for 10 cycles, DEPTH=4 → exactly 4 requests accepted, `req_valid` low thereafter; on release, 4 entries drain in order, then fetching resumes at 0x1010.
- 3-cycle memory latency, 2 requests in flight, `redirect` to 0x2000 → both stale responses discarded; next `out_pc` = 0x2000.
- `redirect` in the same cycle as `resp_valid` and a pop → queue empty next cycle; that response is dropped; `req_addr` = `redirect_pc`.
- `reset` asserted with 3 queued entries and 1 in flight → all outputs at reset values the next cycle; fetch restarts at `RESET_PC`.
- With `FETCH_BYPASS_EN`, empty queue, response of 0x00000013 at cycle N → `out_valid=1`, `out_instr=0x00000013` in cycle N; without it → cycle N+1.
